// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_pipe
// Purpose  : Two-stage pipelined SECDED Hamming decoder with valid/ready
//            handshakes on both sides and saturating error counters.
//            Stage 1 computes the raw syndrome and overall parity error;
//            stage 2 classifies the word, corrects single errors and extracts
//            the data bits into registered outputs.
// Ports    : clk, rst (async, active-low)
//            in_valid / in_ready / code_in[CODE_W]   - upstream handshake
//            out_valid / out_ready                   - downstream handshake
//            data_out[DATA_W], syndrome[PAR_W],
//            err_corr, err_uncorr                    - decode results
//            clr_cnt, corr_cnt[CNT_W], uncorr_cnt    - link monitor counters
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W+P+1, valid for DATA_W in 2..57.
  localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_corr,
  output logic              err_uncorr,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // XOR of the Hamming indices of every set bit at positions 1..CODE_W-1.
  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (c[pos-1]) s = s ^ PAR_W'(pos);
    end
    return s;
  endfunction

  // Data bit k lives at the k-th non-power-of-two Hamming position.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  // Every register advances together; a stalled output freezes the pipe.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // --------------------------------------------------------------------------
  // Stage 1: syndrome and overall parity
  // --------------------------------------------------------------------------
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_pe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_pe    <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_code  <= code_in;
      s1_syn   <= calc_syndrome(code_in);
      s1_pe    <= ^code_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: classify, correct, extract
  // --------------------------------------------------------------------------
  logic [CODE_W-1:0] fixed_code;
  logic              corr_nxt;
  logic              uncorr_nxt;

  always_comb begin
    fixed_code = s1_code;
    corr_nxt   = 1'b0;
    uncorr_nxt = 1'b0;
    if (s1_syn == '0) begin
      // Only the overall parity bit can be wrong; data is untouched.
      corr_nxt = s1_pe;
    end else if (int'(s1_syn) > CODE_W - 1) begin
      // Syndrome points outside the codeword: must be a multi-bit error.
      uncorr_nxt = 1'b1;
    end else if (s1_pe) begin
      corr_nxt = 1'b1;
      for (int pos = 1; pos < CODE_W; pos++) begin
        if (PAR_W'(pos) == s1_syn) fixed_code[pos-1] = ~s1_code[pos-1];
      end
    end else begin
      // Nonzero syndrome with even overall parity: double error.
      uncorr_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      syndrome   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else if (en) begin
      out_valid  <= s1_valid;
      data_out   <= extract_data(fixed_code);
      syndrome   <= s1_syn;
      err_corr   <= corr_nxt;
      err_uncorr <= uncorr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating error counters, updated on output transfer only
  // --------------------------------------------------------------------------
  logic xfer;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (err_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (err_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_pipe
// Purpose  : Directed self-checking bench for hamming_secded_pipe. Three
//            instances: default (DATA_W=4, CNT_W=16), a 2-bit-counter
//            instance for saturation/clear, and a DATA_W=8 instance for an
//            out-of-range syndrome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic       in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [7:0] code_in = '0;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic       err_corr, err_uncorr, clr_cnt = 0;
  logic [15:0] corr_cnt, uncorr_cnt;

  hamming_secded_pipe #(.DATA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  // Saturation instance
  logic       sat_in_valid = 0, sat_in_ready, sat_out_valid, sat_out_ready = 1;
  logic [7:0] sat_code_in = '0;
  logic [3:0] sat_data_out;
  logic [2:0] sat_syndrome;
  logic       sat_err_corr, sat_err_uncorr, sat_clr = 0;
  logic [1:0] sat_corr_cnt, sat_uncorr_cnt;

  hamming_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .code_in(sat_code_in), .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .data_out(sat_data_out), .syndrome(sat_syndrome), .err_corr(sat_err_corr),
    .err_uncorr(sat_err_uncorr), .clr_cnt(sat_clr), .corr_cnt(sat_corr_cnt),
    .uncorr_cnt(sat_uncorr_cnt)
  );

  // Wide instance: DATA_W=8 -> PAR_W=4, CODE_W=13
  logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 1;
  logic [12:0] w_code_in = '0;
  logic [7:0]  w_data_out;
  logic [3:0]  w_syndrome;
  logic        w_err_corr, w_err_uncorr, w_clr = 0;
  logic [15:0] w_corr_cnt, w_uncorr_cnt;

  hamming_secded_pipe #(.DATA_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .code_in(w_code_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .data_out(w_data_out), .syndrome(w_syndrome), .err_corr(w_err_corr),
    .err_uncorr(w_err_uncorr), .clr_cnt(w_clr), .corr_cnt(w_corr_cnt),
    .uncorr_cnt(w_uncorr_cnt)
  );

  // Present one word on the default instance; returns when it is on the outputs.
  task automatic push(input logic [7:0] c);
    @(negedge clk); in_valid = 1; code_in = c;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0h expected 1", in_ready); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL rst_data: got %0h expected 0", data_out); end
    checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
    rst = 1;
  endtask

  task automatic test_clean();
    @(negedge clk); in_valid = 1; code_in = 8'h55;
    @(negedge clk); in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_latency1: out_valid got %0h expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency2: out_valid got %0h expected 1", out_valid); end
    checks++; if (data_out !== 4'b1011) begin errors++; $display("FAIL clean_data: got %0h expected b", data_out); end
    checks++; if (syndrome !== 3'd0) begin errors++; $display("FAIL clean_syn: got %0h expected 0", syndrome); end
    checks++; if (err_corr !== 1'b0 || err_uncorr !== 1'b0) begin errors++; $display("FAIL clean_flags: got %0h%0h expected 00", err_corr, err_uncorr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_bubble: out_valid got %0h expected 0", out_valid); end
    checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL clean_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_corrected();
    push(8'h45);
    checks++; if (syndrome !== 3'b101) begin errors++; $display("FAIL corr5_syn: got %0h expected 5", syndrome); end
    checks++; if (err_corr !== 1'b1 || err_uncorr !== 1'b0) begin errors++; $display("FAIL corr5_flags: got %0h%0h expected 10", err_corr, err_uncorr); end
    checks++; if (data_out !== 4'b1011) begin errors++; $display("FAIL corr5_data: got %0h expected b", data_out); end
    @(negedge clk);
    checks++; if (corr_cnt !== 16'd1) begin errors++; $display("FAIL corr5_cnt: got %0d expected 1", corr_cnt); end
    push(8'hD5);
    checks++; if (syndrome !== 3'd0) begin errors++; $display("FAIL corrp_syn: got %0h expected 0", syndrome); end
    checks++; if (err_corr !== 1'b1 || err_uncorr !== 1'b0) begin errors++; $display("FAIL corrp_flags: got %0h%0h expected 10", err_corr, err_uncorr); end
    checks++; if (data_out !== 4'b1011) begin errors++; $display("FAIL corrp_data: got %0h expected b", data_out); end
    @(negedge clk);
    checks++; if (corr_cnt !== 16'd2) begin errors++; $display("FAIL corrp_cnt: got %0d expected 2", corr_cnt); end
  endtask

  task automatic test_double();
    push(8'h44);
    checks++; if (syndrome !== 3'b100) begin errors++; $display("FAIL dbl_syn: got %0h expected 4", syndrome); end
    checks++; if (err_corr !== 1'b0 || err_uncorr !== 1'b1) begin errors++; $display("FAIL dbl_flags: got %0h%0h expected 01", err_corr, err_uncorr); end
    checks++; if (data_out !== 4'b1001) begin errors++; $display("FAIL dbl_data: got %0h expected 9", data_out); end
    @(negedge clk);
    checks++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd2) begin errors++; $display("FAIL dbl_cnt: got %0d/%0d expected 2/1", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [5];
    logic [3:0] exp_d [5];
    int sent, got;
    logic [3:0] prev_data;
    logic prev_stall;
    words = '{8'h87, 8'h99, 8'hAA, 8'h4B, 8'hFF};
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
    sent = 0; got = 0; prev_data = '0; prev_stall = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 5);
      code_in   = (sent < 5) ? words[sent] : 8'h00;
      #1;
      if (!out_ready && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready: got %0h expected 0", in_ready); end
        if (prev_stall) begin
          checks++; if (data_out !== prev_data) begin errors++; $display("FAIL b2b_stall_hold: got %0h expected %0h", data_out, prev_data); end
        end
        prev_stall = 1; prev_data = data_out;
      end else begin
        prev_stall = 0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (got >= 5) begin errors++; $display("FAIL b2b_extra: got word %0h expected none", data_out); end
        else if (data_out !== exp_d[got]) begin errors++; $display("FAIL b2b_word%0d: got %0h expected %0h", got, data_out, exp_d[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", got); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sat_in_valid = 1; sat_code_in = 8'h45;
    end
    @(negedge clk); sat_in_valid = 0;
    repeat (3) @(negedge clk);
    checks++; if (sat_corr_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", sat_corr_cnt); end
    checks++; if (sat_uncorr_cnt !== 2'd0) begin errors++; $display("FAIL sat_uncorr: got %0d expected 0", sat_uncorr_cnt); end
    @(negedge clk); sat_in_valid = 1; sat_code_in = 8'h45;
    @(negedge clk); sat_in_valid = 0;
    @(negedge clk);
    checks++; if (sat_out_valid !== 1'b1 || sat_err_corr !== 1'b1) begin errors++; $display("FAIL sat_clr_setup: got %0h%0h expected 11", sat_out_valid, sat_err_corr); end
    sat_clr = 1;
    @(negedge clk); sat_clr = 0;
    checks++; if (sat_corr_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr: got %0d expected 0", sat_corr_cnt); end
    @(negedge clk); sat_in_valid = 1; sat_code_in = 8'h45;
    @(negedge clk); sat_in_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (sat_corr_cnt !== 2'd1) begin errors++; $display("FAIL sat_after_clr: got %0d expected 1", sat_corr_cnt); end
  endtask

  task automatic test_wide();
    // Positions 12 and 1 set: syndrome 12^1=13 > CODE_W-1=12.
    @(negedge clk); w_in_valid = 1; w_code_in = 13'h0801;
    @(negedge clk); w_in_valid = 0;
    @(negedge clk);
    checks++; if (w_syndrome !== 4'hD) begin errors++; $display("FAIL wide_syn: got %0h expected d", w_syndrome); end
    checks++; if (w_err_uncorr !== 1'b1 || w_err_corr !== 1'b0) begin errors++; $display("FAIL wide_flags: got %0h%0h expected 01", w_err_corr, w_err_uncorr); end
    checks++; if (w_data_out !== 8'h80) begin errors++; $display("FAIL wide_data: got %0h expected 80", w_data_out); end
    @(negedge clk);
    checks++; if (w_uncorr_cnt !== 16'd1) begin errors++; $display("FAIL wide_cnt: got %0d expected 1", w_uncorr_cnt); end
    // Single error at position 12 (d7) of an all-zero word.
    @(negedge clk); w_in_valid = 1; w_code_in = 13'h0800;
    @(negedge clk); w_in_valid = 0;
    @(negedge clk);
    checks++; if (w_syndrome !== 4'hC || w_err_corr !== 1'b1) begin errors++; $display("FAIL wide_corr: got syn %0h corr %0h expected c 1", w_syndrome, w_err_corr); end
    checks++; if (w_data_out !== 8'h00) begin errors++; $display("FAIL wide_corr_data: got %0h expected 0", w_data_out); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); in_valid = 1; code_in = 8'h45;
    @(negedge clk); code_in = 8'h44;
    @(negedge clk); in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: out_valid got %0h expected 1", out_valid); end
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0h expected 0", out_valid); end
    checks++; if (data_out !== 4'h0 || syndrome !== 3'h0) begin errors++; $display("FAIL mid_rst_data: got %0h/%0h expected 0/0", data_out, syndrome); end
    checks++; if (err_corr !== 1'b0 || err_uncorr !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %0h%0h expected 00", err_corr, err_uncorr); end
    checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0h expected 1", in_ready); end
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: out_valid got %0h expected 0", out_valid); end
    push(8'h55);
    checks++; if (out_valid !== 1'b1 || data_out !== 4'b1011) begin errors++; $display("FAIL mid_after: got v%0h d%0h expected v1 db", out_valid, data_out); end
    checks++; if (err_corr !== 1'b0 || err_uncorr !== 1'b0) begin errors++; $display("FAIL mid_after_flags: got %0h%0h expected 00", err_corr, err_uncorr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean();
    test_corrected();
    test_double();
    test_back_to_back();
    test_saturation();
    test_wide();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
